// File: rtl/wallace_dot_pkg.sv
// Shared constants and helpers for the wallace multiply-accumulate stage.
package wallace_dot_pkg;

  localparam int MUL_W  = 4;
  localparam int PROD_W = 8;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  // Sum/carry pair produced by one layer of 3:2 compressors.
  typedef struct packed {
    logic [PROD_W-1:0] s;
    logic [PROD_W-1:0] c;
  } csa_t;

  // Bitwise 3:2 compression; the carry vector is already weighted (shifted left).
  function automatic csa_t csa3(input logic [PROD_W-1:0] a,
                                input logic [PROD_W-1:0] b,
                                input logic [PROD_W-1:0] d);
    csa_t r;
    r.s = a ^ b ^ d;
    r.c = ((a & b) | (a & d) | (b & d)) << 1;
    return r;
  endfunction

endpackage

// File: rtl/wallace.sv
// 4x4 unsigned Wallace-tree multiplier: partial products, two CSA layers, final adder.
module wallace
  import wallace_dot_pkg::*;
(
  input  logic [MUL_W-1:0]  x,
  input  logic [MUL_W-1:0]  y,
  output logic [PROD_W-1:0] out
);

  logic [PROD_W-1:0] pp [MUL_W];
  csa_t              l1;
  csa_t              l2;

  // Partial-product rows, each row already shifted to its weight.
  // NOTE: purely combinational block; every output is assigned on every pass, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < MUL_W; i++) begin
      pp[i] = PROD_W'(x & {MUL_W{y[i]}}) << i;
    end
  end

  // Four rows reduce to three, then to two; the product fits in 8 bits so wrap is exact.
  assign l1  = csa3(pp[0], pp[1], pp[2]);
  assign l2  = csa3(l1.s, l1.c, pp[3]);
  assign out = l2.s + l2.c;

endmodule

// File: rtl/wallace_dot_acc.sv
// Streaming dot-product accumulator: operand register stage, wallace multiplier,
// wide accumulator with sticky carry-out and saturating pair counter.
module wallace_dot_acc
  import wallace_dot_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MUL_W-1:0] in_a,
  input  logic [MUL_W-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  logic [1:0]        state;
  logic [MUL_W-1:0]  a_q;
  logic [MUL_W-1:0]  b_q;
  logic              last1;
  logic              v1;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic [ACC_W:0]    sum_ext;
  logic              in_hs;
  logic              out_hs;

  // in_ready and out_valid decode the state register only, so neither has a
  // combinational path from the opposite handshake inputs.
  assign in_ready  = (state == ST_RUN);
  assign out_valid = (state == ST_OUT);
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;

  assign sum_ext   = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

  assign out_sum   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

  wallace u_wallace (
    .x   (a_q),
    .y   (b_q),
    .out (prod)
  );

  // Vector-framing FSM: collect pairs, let the last one drain through S2, hold the result.
  // NOTE: reset is synchronous here, so it is tested inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (in_hs && in_last) state <= ST_DRAIN;
        ST_DRAIN: if (v1 && last1)      state <= ST_OUT;
        ST_OUT:   if (out_hs)           state <= ST_RUN;
        default:                        state <= ST_RUN;
      endcase
    end
  end

  // S1: capture the accepted operand pair; v1 marks a pair waiting in the multiplier.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      last1 <= 1'b0;
      v1    <= 1'b0;
    end else begin
      v1 <= in_hs;
      if (in_hs) begin
        a_q   <= in_a;
        b_q   <= in_b;
        last1 <= in_last;
      end
    end
  end

  // S2: accumulate products, keep carry-out sticky, count pairs with saturation;
  // the result handshake clears everything for the next vector.
  always_ff @(posedge clk) begin
    if (!rst_n || out_hs) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (v1) begin
      acc <= sum_ext[ACC_W-1:0];
      ovf <= ovf | sum_ext[ACC_W];
      if (count != {CNT_W{1'b1}}) count <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wallace_dot_acc.sv
// Self-checking bench: two instances (ACC_W=16 and ACC_W=10) driven in lockstep and
// compared against an arithmetic dot-product model.
module tb_wallace_dot_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic        in_last;
  logic        out_ready;

  logic        ready16, valid16, ovf16;
  logic [15:0] sum16;
  logic [7:0]  cnt16;
  logic        ready10, valid10, ovf10;
  logic [9:0]  sum10;
  logic [7:0]  cnt10;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: true (unbounded) dot product and pair count of the open vector.
  longint exp_total = 0;
  int     exp_n     = 0;

  always #5 clk = ~clk;

  wallace_dot_acc dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready16),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(valid16),
    .out_ready(out_ready), .out_sum(sum16), .out_count(cnt16), .out_ovf(ovf16)
  );

  wallace_dot_acc #(.ACC_W(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready10),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(valid10),
    .out_ready(out_ready), .out_sum(sum10), .out_count(cnt10), .out_ovf(ovf10)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint exp_sum(input int w);
    return exp_total % (64'd1 << w);
  endfunction

  function automatic longint exp_ovf(input int w);
    return (exp_total >= (64'd1 << w)) ? 1 : 0;
  endfunction

  function automatic longint exp_cnt();
    return (exp_n > 255) ? 255 : exp_n;
  endfunction

  // Present one pair and wait (bounded) for it to be accepted.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic last);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    while (!ready16 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!ready16) begin
      check("in_ready_timeout", 0, 1);
    end else begin
      @(posedge clk);
      exp_total += longint'(a) * longint'(b);
      exp_n++;
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_a = 4'($urandom); in_b = 4'($urandom); in_last = 1'($urandom);
    end
  endtask

  // Called right after the last pair's accepting edge: checks latency, result,
  // stability during a back-pressure window of 'hold' cycles, then accepts it.
  task automatic finish_vector(input string name, input int hold);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check({name, ".valid_edge1"}, valid16, 0);
    check({name, ".ready_drain"}, ready16, 0);
    @(negedge clk);
    check({name, ".valid_edge2"}, valid16, 1);
    check({name, ".sum16"}, sum16, exp_sum(16));
    check({name, ".cnt16"}, cnt16, exp_cnt());
    check({name, ".ovf16"}, ovf16, exp_ovf(16));
    check({name, ".sum10"}, sum10, exp_sum(10));
    check({name, ".ovf10"}, ovf10, exp_ovf(10));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); in_a = 4'($urandom); in_b = 4'($urandom);
      in_last = 1'($urandom);
      @(negedge clk);
      check({name, ".hold_valid"}, valid16, 1);
      check({name, ".hold_ready"}, ready16, 0);
      check({name, ".hold_sum"}, sum16, exp_sum(16));
      check({name, ".hold_cnt"}, cnt16, exp_cnt());
      check({name, ".hold_ovf10"}, ovf10, exp_ovf(10));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, ".valid_after_hs"}, valid16, 0);
    check({name, ".ready_after_hs"}, ready16, 1);
    check({name, ".sum_cleared"}, sum16, 0);
    check({name, ".cnt_cleared"}, cnt16, 0);
    check({name, ".ovf10_cleared"}, ovf10, 0);
    exp_total = 0;
    exp_n = 0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst.valid", valid16, 0);
    check("rst.sum", sum16, 0);
    check("rst.cnt", cnt16, 0);
    check("rst.ovf", ovf16, 0);
    check("rst.ready", ready16, 1);

    // Basic three-pair vector.
    send(2, 3, 0); send(1, 4, 0); send(8, 6, 1);
    check("t1.model_sum", exp_total, 58);
    finish_vector("t1", 0);

    // One-pair vector at maximum operands.
    send(15, 15, 1);
    finish_vector("t2", 0);

    // Five max pairs wrap the 10-bit accumulator; next vector must start clean.
    for (int i = 0; i < 5; i++) send(15, 15, (i == 4));
    finish_vector("t3", 0);
    send(2, 2, 1);
    finish_vector("t3b", 0);

    // Back-pressure with ignored input pulses.
    send(7, 9, 0); send(3, 11, 1);
    finish_vector("t4", 5);

    // in_valid gaps inside a vector.
    send(3, 3, 0); idle(2); send(5, 7, 1);
    finish_vector("t5", 0);

    // Reset aborts a partial vector.
    send(9, 9, 0); send(4, 4, 0);
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_total = 0; exp_n = 0;
    check("t6.sum", sum16, 0);
    check("t6.cnt", cnt16, 0);
    check("t6.ovf10", ovf10, 0);
    check("t6.valid", valid16, 0);
    check("t6.ready", ready16, 1);
    send(1, 1, 1);
    finish_vector("t6b", 0);

    // Long vector: count saturates at 255.
    for (int i = 0; i < 260; i++) send(4'($urandom), 4'($urandom), (i == 259));
    finish_vector("sat", 1);

    // Randomized vectors with random gaps and back-pressure.
    for (int v = 0; v < 25; v++) begin
      int len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send(4'($urandom), 4'($urandom), (i == len - 1));
      end
      finish_vector("rand", $urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
